// File: rtl/scan_link_scheduler.sv
// scan_link_scheduler: arbitrates one serial transfer link between two
// scanner buffers (A, B) by buffer-fill urgency.
//
// Each grant sends a command byte (urgency code 1..4), the 8'd7 header and
// up to BURST data bytes, MSB first, 8 tx_valid cycles per byte.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   level_a, level_b    buffer occupancy (LVL_W bits)
//   data_a, data_b      FWFT head bytes
//   peer_ready          remote side can accept a burst
//   tx_bit, tx_valid    serial data and qualifier
//   tx_frame            high on bit 7 of every byte
//   grant_a, grant_b    link owner during command/header/data
//   pop_a, pop_b        head byte consumed (first bit cycle of a data byte)
//   busy                FSM not idle
//
// Optional feature macro: LINK_IDLE_POLL_EN. When defined, an idle link
// sends an 8'd6 poll byte after POLL_INTERVAL idle cycles.

module scan_link_scheduler #(
    parameter int BUF_DEPTH     = 64,
    parameter int LVL_W         = 7,
    parameter int BURST         = 8,
    parameter int POLL_INTERVAL = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W-1:0] level_a,
    input  logic [LVL_W-1:0] level_b,
    input  logic [7:0]       data_a,
    input  logic [7:0]       data_b,
    input  logic             peer_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             tx_frame,
    output logic             grant_a,
    output logic             grant_b,
    output logic             pop_a,
    output logic             pop_b,
    output logic             busy
);

    localparam int T4 = BUF_DEPTH;
    localparam int T3 = BUF_DEPTH * 9 / 10;
    localparam int T2 = BUF_DEPTH * 4 / 5;
    localparam int T1 = BUF_DEPTH / 2;

    localparam logic [7:0] HDR_BYTE = 8'd7;

    if (BURST < 1 || BURST > 255) begin : g_chk_burst
        $error("BURST must be 1..255");
    end
    if (BUF_DEPTH < 2 || (64'd1 << LVL_W) <= 64'(BUF_DEPTH)) begin : g_chk_lvl
        $error("LVL_W must hold BUF_DEPTH (>=2)");
    end
    if (POLL_INTERVAL < 1) begin : g_chk_poll
        $error("POLL_INTERVAL must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        HDR,
        DATA,
        POLL
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] left_q, left_d;
    logic       sel_q, sel_d;
    logic       rr_q, rr_d;
    logic       abort_q, abort_d;

`ifdef LINK_IDLE_POLL_EN
    localparam logic [7:0] POLL_BYTE = 8'd6;
    localparam int PW = $clog2(POLL_INTERVAL + 1);
    logic [PW-1:0] poll_q, poll_d;
`endif

    logic [2:0]       code_a, code_b;
    logic             req, pick_b, stop, last_bit, owned;
    logic [LVL_W-1:0] lvl_pick;
    logic [7:0]       len, data_sel;

    function automatic logic [2:0] urgency(input logic [LVL_W-1:0] lvl);
        int v;
        v = int'(lvl);
        if (v >= T4)      return 3'd4;
        else if (v >= T3) return 3'd3;
        else if (v >= T2) return 3'd2;
        else if (v >= T1) return 3'd1;
        else              return 3'd0;
    endfunction

    always_comb begin
        code_a   = urgency(level_a);
        code_b   = urgency(level_b);
        req      = peer_ready && (code_a != 3'd0 || code_b != 3'd0);
        // ties go to the scanner named by the round-robin pointer
        pick_b   = (code_b > code_a) || ((code_b == code_a) && rr_q);
        lvl_pick = pick_b ? level_b : level_a;
        len      = (int'(lvl_pick) >= BURST) ? 8'(BURST) : 8'(lvl_pick);
        data_sel = sel_q ? data_b : data_a;
        last_bit = (bit_q == 3'd0);
        // a peer drop anywhere in the byte ends the grant at its last bit
        stop     = abort_q || !peer_ready;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        left_d  = left_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        abort_d = abort_q;
`ifdef LINK_IDLE_POLL_EN
        poll_d  = poll_q;
`endif

        if (state_q != IDLE) begin
            bit_d = bit_q - 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
        end

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (req) begin
                    state_d = CMD;
                    sel_d   = pick_b;
                    sh_d    = {5'd0, pick_b ? code_b : code_a};
                    bit_d   = 3'd7;
                    left_d  = len - 8'd1;
`ifdef LINK_IDLE_POLL_EN
                    poll_d  = '0;
                end else if (poll_q == PW'(POLL_INTERVAL - 1)) begin
                    state_d = POLL;
                    sh_d    = POLL_BYTE;
                    bit_d   = 3'd7;
                    poll_d  = '0;
                end else begin
                    poll_d  = poll_q + PW'(1);
`endif
                end
            end
            CMD, HDR, DATA: begin
                if (!peer_ready) abort_d = 1'b1;
                if (last_bit) begin
                    if (stop || (state_q == DATA && left_q == 8'd0)) begin
                        state_d = IDLE;
                        rr_d    = ~rr_q;
                    end else if (state_q == CMD) begin
                        state_d = HDR;
                        sh_d    = HDR_BYTE;
                    end else begin
                        // data_x sampled at the edge that starts the byte
                        state_d = DATA;
                        sh_d    = data_sel;
                        if (state_q == DATA) left_d = left_q - 8'd1;
                    end
                end
            end
            POLL: begin
                if (last_bit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= 8'd0;
            bit_q   <= 3'd0;
            left_q  <= 8'd0;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            abort_q <= 1'b0;
`ifdef LINK_IDLE_POLL_EN
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            left_q  <= left_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            abort_q <= abort_d;
`ifdef LINK_IDLE_POLL_EN
            poll_q  <= poll_d;
`endif
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        owned    = (state_q == CMD) || (state_q == HDR) || (state_q == DATA);
        tx_valid = busy;
        tx_bit   = busy && sh_q[7];
        tx_frame = busy && (bit_q == 3'd7);
        grant_a  = owned && !sel_q;
        grant_b  = owned && sel_q;
        pop_a    = (state_q == DATA) && (bit_q == 3'd7) && !sel_q;
        pop_b    = (state_q == DATA) && (bit_q == 3'd7) && sel_q;
    end

endmodule

// File: tb/tb_scan_link_scheduler.sv
// Scoreboard bench for scan_link_scheduler: directed grants push expected
// bytes; a monitor deserialises the link and checks each completed byte.

module tb_scan_link_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] level_a, level_b;
    logic [7:0] data_a, data_b;
    logic       peer_ready;
    logic       tx_bit, tx_valid, tx_frame;
    logic       grant_a, grant_b, pop_a, pop_b, busy;

    always #5 clk = ~clk;

    scan_link_scheduler #(
        .BUF_DEPTH(64),
        .LVL_W(7),
        .BURST(8),
        .POLL_INTERVAL(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .level_a(level_a),
        .level_b(level_b),
        .data_a(data_a),
        .data_b(data_b),
        .peer_ready(peer_ready),
        .tx_bit(tx_bit),
        .tx_valid(tx_valid),
        .tx_frame(tx_frame),
        .grant_a(grant_a),
        .grant_b(grant_b),
        .pop_a(pop_a),
        .pop_b(pop_b),
        .busy(busy)
    );

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] own;
        logic       pop;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   inv_bad = 0;
    int   polls = 0;
    int   idx_a = 0;
    int   idx_b = 0;
    int   ea = 0;
    int   eb = 0;

    // FWFT head model: head advances after each pop
    assign data_a = 8'hA0 + 8'(idx_a);
    assign data_b = 8'hB0 + 8'(idx_b);

    always @(posedge clk) begin
        if (pop_a) idx_a <= idx_a + 1;
        if (pop_b) idx_b <= idx_b + 1;
    end

    task automatic cmp(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input logic [1:0] own,
                        input logic pop);
        exp_t e;
        e.b   = b;
        e.own = own;
        e.pop = pop;
        expq.push_back(e);
    endtask

    task automatic check_byte(input logic [7:0] b, input logic [1:0] own,
                              input logic pop);
        exp_t e;
        n_cmp++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL byte: got %02h own %0d, nothing expected", b, own);
        end else begin
            e = expq.pop_front();
            if (b !== e.b || own !== e.own || pop !== e.pop) begin
                n_fail++;
                $display("FAIL byte: got %02h own %0d pop %0d expected %02h own %0d pop %0d",
                         b, own, pop, e.b, e.own, e.pop);
            end
        end
    endtask

    // link monitor
    initial begin
        logic [7:0] m_sh;
        logic [1:0] m_own;
        logic       m_pop;
        int         m_cnt;
        m_sh  = 8'd0;
        m_own = 2'd0;
        m_pop = 1'b0;
        m_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_cnt = 0;
            end else begin
                if ((grant_a && grant_b) || (pop_a && !grant_a) ||
                    (pop_b && !grant_b) || ((pop_a || pop_b) && !tx_frame))
                    inv_bad++;
                if (tx_valid) begin
                    if (tx_frame) begin
                        if (m_cnt != 0) inv_bad++;
                        m_sh  = {7'd0, tx_bit};
                        m_cnt = 1;
                        m_own = grant_a ? 2'd1 : (grant_b ? 2'd2 : 2'd0);
                        m_pop = grant_a ? pop_a : pop_b;
                    end else if (m_cnt > 0) begin
                        m_sh  = {m_sh[6:0], tx_bit};
                        m_cnt++;
                    end else begin
                        inv_bad++;
                    end
                    if (m_cnt == 8) begin
                        m_cnt = 0;
`ifdef LINK_IDLE_POLL_EN
                        if (m_own == 2'd0 && m_sh == 8'd6) polls++;
                        else
`endif
                        check_byte(m_sh, m_own, m_pop);
                    end
                end
            end
        end
    end

    task automatic wait_grant(output bit ok);
        int c;
        c = 0;
        while (!(grant_a || grant_b) && c < 200) begin
            @(negedge clk);
            c++;
        end
        ok = grant_a || grant_b;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_wait: got no grant in %0d cycles, required a grant", c);
        end
    endtask

    // one full grant; own 1=A 2=B; keep leaves the loser's level in place
    task automatic run_grant(input string name, input int la, input int lb,
                             input int own, input int code, input int len,
                             input bit keep);
        bit ok;
        int cyc;
        push(8'(code), 2'(own), 1'b0);
        push(8'd7, 2'(own), 1'b0);
        for (int i = 0; i < len; i++) begin
            if (own == 1) begin
                push(8'hA0 + 8'(ea), 2'd1, 1'b1);
                ea++;
            end else begin
                push(8'hB0 + 8'(eb), 2'd2, 1'b1);
                eb++;
            end
        end
        level_a = 7'(la);
        level_b = 7'(lb);
        wait_grant(ok);
        if (ok) begin
            cmp({name, " owner"}, grant_b ? 2 : 1, own);
            if (keep) begin
                if (grant_a) level_a = 7'd0;
                else level_b = 7'd0;
            end else begin
                level_a = 7'd0;
                level_b = 7'd0;
            end
            cyc = 0;
            while ((grant_a || grant_b) && cyc < 400) begin
                cyc++;
                @(negedge clk);
            end
            cmp({name, " grant_cycles"}, cyc, 8 * (2 + len));
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int vcnt;
        int fcnt;
        int gcnt;
        rst        = 1'b1;
        level_a    = 7'd0;
        level_b    = 7'd0;
        peer_ready = 1'b0;
        tick(3);
        cmp("reset_outputs", int'({tx_bit, tx_valid, tx_frame, grant_a,
                                   grant_b, pop_a, pop_b, busy}), 0);
        rst        = 1'b0;
        peer_ready = 1'b1;

        vcnt = 0;
        fcnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            if (tx_valid) vcnt++;
            if (tx_valid && tx_frame) fcnt++;
        end
`ifdef LINK_IDLE_POLL_EN
        cmp("idle_poll_frames", fcnt, 2);
        cmp("idle_poll_bits", vcnt, 16);
`else
        cmp("idle_frames", fcnt, 0);
        cmp("idle_silent", vcnt, 0);
`endif

        level_a = 7'd31;
        level_b = 7'd31;
        gcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (grant_a || grant_b) gcnt++;
        end
        cmp("below_threshold", gcnt, 0);
        level_a = 7'd0;
        level_b = 7'd0;
        tick(1);

        run_grant("t1_a40", 40, 0, 1, 1, 8, 1'b0);
        run_grant("t2_b64", 52, 64, 2, 4, 8, 1'b1);
        run_grant("t2_a52", 52, 0, 1, 2, 8, 1'b0);

        // peer drop on bit 3 of data byte 2
        push(8'd1, 2'd1, 1'b0);
        push(8'd7, 2'd1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push(8'hA0 + 8'(ea), 2'd1, 1'b1);
            ea++;
        end
        level_a = 7'd40;
        level_b = 7'd0;
        wait_grant(ok);
        if (ok) begin
            cmp("t4 owner", grant_b ? 2 : 1, 1);
            tick(28);
            peer_ready = 1'b0;
            tick(3);
            cmp("t4_busy_last_bit", int'(busy), 1);
            tick(1);
            cmp("t4_idle_after", int'({busy, grant_a}), 0);
            level_a = 7'd0;
            tick(4);
            peer_ready = 1'b1;
            tick(2);
        end

        run_grant("t3_1", 60, 60, 1, 3, 8, 1'b0);
        run_grant("t3_2", 60, 60, 2, 3, 8, 1'b0);
        run_grant("t3_3", 60, 60, 1, 3, 8, 1'b0);
        run_grant("thr_57_56", 57, 56, 1, 3, 8, 1'b0);
        run_grant("thr_50_51", 50, 51, 2, 2, 8, 1'b0);

        // reset in the middle of the header byte
        push(8'd3, 2'd2, 1'b0);
        level_a = 7'd60;
        level_b = 7'd60;
        wait_grant(ok);
        if (ok) begin
            cmp("t5 owner", grant_b ? 2 : 1, 2);
            tick(10);
            rst = 1'b1;
            tick(1);
            cmp("t5_rst_outputs", int'({tx_bit, tx_valid, tx_frame, grant_a,
                                        grant_b, pop_a, pop_b, busy}), 0);
            level_a = 7'd0;
            level_b = 7'd0;
            tick(1);
            rst = 1'b0;
        end
        run_grant("after_rst", 60, 60, 1, 3, 8, 1'b0);

        tick(20);
        cmp("exp_queue_left", expq.size(), 0);
        cmp("invariants", inv_bad, 0);
        cmp("pops_a", idx_a, ea);
        cmp("pops_b", idx_b, eb);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
